seq_pattern_gen: RTL and testbench
==================================

Name: seq_pattern_gen

Overview:
- Serial stimulus transmitter for the overlapping "1011" Moore detector. Accepts a parallel pattern word over a valid/ready load handshake and emits it MSB-first, one bit per clock, a programmable number of times.
- Tracks the emitted stream with an internal overlapping 1011 Moore model and reports the expected detection count, so benches and self-test logic can check the detector.

Parameters:
- WIDTH, 16, maximum pattern length in bits.
- LEN_W, $clog2(WIDTH+1), width of the length field.
- REP_W, 4, width of the repeat field.
- CNT_W, 8, width of the expected-match counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- load_valid  input  1  load request
- load_ready  output  1  high only in IDLE (combinational from state)
- load_data  input  WIDTH  pattern; bit len-1 is sent first
- load_len  input  LEN_W  bits per pass; values above WIDTH are clamped to WIDTH
- load_rep  input  REP_W  extra passes; total passes = load_rep+1
- pause  input  1  stall emission while high
- out  output  1  serial bit, valid when out_valid=1, 0 otherwise
- out_valid  output  1  out carries a stream bit this cycle
- busy  output  1  high in SHIFT
- done  output  1  one-cycle pulse after the last bit
- match_cnt  output  CNT_W  overlapping 1011 completions emitted since the last accept

Behaviour:
- Reset (rst=1 at an edge), from any state including mid-stream:
  - state goes to IDLE; out=0, out_valid=0, done=0, busy=0, match_cnt=0.
  - tracker goes to T0; pattern, length, pass and bit registers are cleared.
- FSM states are IDLE and SHIFT.
- IDLE:
  - Accept occurs when load_valid && load_ready at an edge.
  - On accept: latch data, clamped length and rep; bit index = len-1; pass counter = rep; match_cnt=0; tracker=T0; go to SHIFT.
  - load_valid with no accept has no effect. While in SHIFT, load_ready=0 and loads are ignored (not queued).
- SHIFT, at each edge:
  - pause=1: out_valid<=0 and out<=0. Index, pass counter and tracker hold.
  - pause=0 with bits remaining:
    - out<=data[index] and out_valid<=1.
    - Tracker advances on that bit; match_cnt updates in the same edge.
    - If index=0 and passes remain: index<=len-1 and the pass counter decrements.
    - Otherwise the index decrements.
  - pause=0 with all bits emitted: out_valid<=0, out<=0, done<=1 for one cycle, go to IDLE. A len of 0 takes this path on the first non-paused edge, with no bits emitted and match_cnt=0.
- Latency:
  - Accept at edge E0; first bit is visible after the first non-paused edge following E0.
  - Unpaused, bits occupy len*(rep+1) consecutive cycles, and done follows in the next cycle.
- Tracker (overlapping 1011 Moore model), next state per emitted bit:
  - T0: 1→T1, 0→T0.
  - T1: 1→T1, 0→T2.
  - T2: 1→T3, 0→T0.
  - T3: 1→T4, 0→T2.
  - T4: 1→T1, 0→T2.
  - Entering T4 increments match_cnt.
- Tracker state carries across pass boundaries, because the stream is continuous.
- match_cnt saturates at 2^CNT_W-1 and holds its final value from done until the next accept or reset.
- busy=1 exactly while in SHIFT. done and load_ready are never high in the same cycle as busy.
- rst has priority over every other input, including a load or pause in the same cycle.

Test Plan:
- Single pass with overlap: load_data=7'b1011011, len=7, rep=0, pause=0.
  - out_valid high for 7 consecutive cycles, with out = 1,0,1,1,0,1,1.
  - done pulses in the 8th cycle; final match_cnt=2.
- Repeat: data=4'b1011, len=4, rep=2.
  - Stream is 101110111011 (12 valid cycles); match_cnt=3; a single done pulse.
- Match spanning a pass boundary: data=3'b101, len=3, rep=1.
  - Stream is 101101; match_cnt=1, incremented on the 4th bit.
- Pause and ignored load:
  - Assert pause for 3 cycles after the 2nd bit of 1011: out_valid=0 for those 3 cycles, then the bits resume at 1,1 with no bit lost or repeated; match_cnt=1.
  - A load_valid pulse during SHIFT is ignored and load_ready stays 0.
- Edge lengths:
  - len=0: done pulses with out_valid never high and match_cnt=0.
  - len=31 with WIDTH=16: clamped to 16 bits.
- Reset mid-stream: assert rst during the 3rd bit of a rep=3 load.
  - The next cycle shows all outputs 0, state IDLE and load_ready=1.
  - A new load then runs normally from match_cnt=0.

Source files
------------

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: emits a loaded word MSB-first for rep+1 passes and
// counts the overlapping "1011" completions a Moore detector should report.
module seq_pattern_gen #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LEN_W = $clog2(WIDTH + 1),
  parameter int unsigned REP_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  input  logic [REP_W-1:0] load_rep,
  input  logic             pause,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt
);

  typedef enum logic {IDLE, SHIFT} state_e;
  typedef enum logic [2:0] {T0, T1, T2, T3, T4} trk_e;

  state_e            state_q, state_d;
  trk_e              trk_q, trk_d, trk_nxt;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [REP_W-1:0]  pass_q, pass_d;
  logic              fin_q, fin_d;
  logic              out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  match_q, match_d;
  logic [LEN_W-1:0]  len_clamp;
  logic [WIDTH-1:0]  shifted;
  logic              cur_bit;

  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q == SHIFT);
  assign out        = out_q;
  assign out_valid  = out_valid_q;
  assign done       = done_q;
  assign match_cnt  = match_q;

  assign len_clamp = (load_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : load_len;
  assign shifted   = data_q >> idx_q;
  assign cur_bit   = shifted[0];

  always_comb begin
    trk_nxt = T0;
    case (trk_q)
      T0:      trk_nxt = cur_bit ? T1 : T0;
      T1:      trk_nxt = cur_bit ? T1 : T2;
      T2:      trk_nxt = cur_bit ? T3 : T0;
      T3:      trk_nxt = cur_bit ? T4 : T2;
      T4:      trk_nxt = cur_bit ? T1 : T2;
      default: trk_nxt = T0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    trk_d       = trk_q;
    data_d      = data_q;
    len_d       = len_q;
    idx_d       = idx_q;
    pass_d      = pass_q;
    fin_d       = fin_q;
    match_d     = match_q;
    out_d       = 1'b0;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          data_d  = load_data;
          len_d   = len_clamp;
          pass_d  = load_rep;
          // fin marks "nothing left to emit", so len=0 goes straight to done
          idx_d   = (len_clamp == '0) ? '0 : len_clamp - LEN_W'(1);
          fin_d   = (len_clamp == '0);
          match_d = '0;
          trk_d   = T0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!pause) begin
          if (!fin_q) begin
            out_d       = cur_bit;
            out_valid_d = 1'b1;
            trk_d       = trk_nxt;
            if (trk_nxt == T4 && match_q != '1) match_d = match_q + CNT_W'(1);
            if (idx_q == '0) begin
              if (pass_q != '0) begin
                idx_d  = len_q - LEN_W'(1);
                pass_d = pass_q - REP_W'(1);
              end else begin
                fin_d = 1'b1;
              end
            end else begin
              idx_d = idx_q - LEN_W'(1);
            end
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      trk_q       <= T0;
      data_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      pass_q      <= '0;
      fin_q       <= 1'b0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      match_q     <= '0;
    end else begin
      state_q     <= state_d;
      trk_q       <= trk_d;
      data_q      <= data_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      pass_q      <= pass_d;
      fin_q       <= fin_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      match_q     <= match_d;
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: queue-based stream model compared every cycle,
// plus literal stream/count expectations for each directed scenario.
module tb_seq_pattern_gen;
  localparam int WIDTH = 16;
  localparam int LEN_W = 5;
  localparam int REP_W = 4;
  localparam int CNT_W = 5;

  logic clk = 1'b0;
  logic rst, load_valid, pause;
  logic [WIDTH-1:0] load_data;
  logic [LEN_W-1:0] load_len;
  logic [REP_W-1:0] load_rep;
  logic load_ready, out, out_valid, busy, done;
  logic [CNT_W-1:0] match_cnt;

  always #5 clk = ~clk;

  seq_pattern_gen #(.WIDTH(WIDTH), .LEN_W(LEN_W), .REP_W(REP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_len(load_len), .load_rep(load_rep), .pause(pause),
    .out(out), .out_valid(out_valid), .busy(busy), .done(done), .match_cnt(match_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: the whole stream is expanded into a queue at accept time; matches are
  // counted by looking at the last four emitted bits.
  bit   q_bits[$];
  bit   m_busy, m_out, m_ov, m_done, m_b;
  int   m_cnt, m_len;
  bit [3:0] hist;
  bit   chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_out = 0; m_ov = 0; m_done = 0; m_cnt = 0; hist = '0;
      q_bits.delete();
    end else if (!m_busy) begin
      m_out = 0; m_ov = 0; m_done = 0;
      if (load_valid) begin
        m_len = (int'(load_len) > WIDTH) ? WIDTH : int'(load_len);
        q_bits.delete();
        for (int p = 0; p <= int'(load_rep); p++)
          for (int i = m_len - 1; i >= 0; i--) q_bits.push_back(load_data[i]);
        m_busy = 1; m_cnt = 0; hist = '0;
      end
    end else if (pause) begin
      m_out = 0; m_ov = 0; m_done = 0;
    end else if (q_bits.size() > 0) begin
      m_b = q_bits.pop_front();
      m_out = m_b; m_ov = 1; m_done = 0;
      hist = {hist[2:0], m_b};
      if (hist == 4'b1011 && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end else begin
      m_out = 0; m_ov = 0; m_done = 1; m_busy = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("out", out, m_out);
      check("out_valid", out_valid, m_ov);
      check("done", done, m_done);
      check("busy", busy, m_busy);
      check("load_ready", load_ready, !m_busy);
      check("match_cnt", match_cnt, m_cnt);
    end
  end

  bit cap[$];
  int done_n = 0;
  always @(negedge clk) begin
    if (out_valid === 1'b1) cap.push_back(out);
    if (done === 1'b1) done_n++;
  end

  task automatic start(input logic [WIDTH-1:0] d, input int len, input int rep);
    int t = 0;
    while (load_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    check("ready_wait", (t < 50), 1);
    cap.delete(); done_n = 0;
    load_data = d; load_len = LEN_W'(len); load_rep = REP_W'(rep); load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    bit seen = 0;
    while (!seen && t < 400) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
      t++;
    end
    check({name, "_done_seen"}, seen, 1);
    @(posedge clk); #1;
  endtask

  task automatic check_stream(input string name, input logic [31:0] exp, input int n);
    logic [31:0] a = '0;
    foreach (cap[i]) a = {a[30:0], cap[i]};
    check({name, "_len"}, cap.size(), n);
    check({name, "_bits"}, a, exp);
    check({name, "_done_n"}, done_n, 1);
  endtask

  initial begin
    rst = 1; load_valid = 0; pause = 0; load_data = '0; load_len = '0; load_rep = '0;
    @(posedge clk); #1; chk_en = 1;
    @(posedge clk); #1;
    check("rst_ready", load_ready, 1);
    check("rst_cnt", match_cnt, 0);
    check("rst_ov", out_valid, 0);
    rst = 0;

    start(16'b1011011, 7, 0); wait_done("t1");
    check_stream("t1", 32'b1011011, 7); check("t1_cnt", match_cnt, 2);

    start(16'b1011, 4, 2); wait_done("t2");
    check_stream("t2", 32'b101110111011, 12); check("t2_cnt", match_cnt, 3);

    start(16'b101, 3, 1); wait_done("t3");
    check_stream("t3", 32'b101101, 6); check("t3_cnt", match_cnt, 1);

    start(16'b1011, 4, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    pause = 1; load_valid = 1; load_data = 16'hFFFF; load_len = 5'd4;
    check("t4_ready_in_shift", load_ready, 0);
    @(posedge clk); #1; load_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t4_bits_during_pause", cap.size(), 2);
    pause = 0;
    wait_done("t4");
    check_stream("t4", 32'b1011, 4); check("t4_cnt", match_cnt, 1);

    start(16'h0, 0, 2); wait_done("t5");
    check_stream("t5", 32'h0, 0); check("t5_cnt", match_cnt, 0);

    start(16'hB2D1, 31, 0); wait_done("t6");
    check_stream("t6", 32'hB2D1, 16); check("t6_cnt", match_cnt, 2);

    start(16'b1101, 4, 3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1; load_valid = 1;
    @(posedge clk); #1;
    load_valid = 0;
    check("t7_busy", busy, 0); check("t7_ready", load_ready, 1);
    check("t7_ov", out_valid, 0); check("t7_out", out, 0);
    check("t7_done", done, 0); check("t7_cnt", match_cnt, 0);
    rst = 0;
    start(16'b1011, 4, 0); wait_done("t7b");
    check_stream("t7b", 32'b1011, 4); check("t7b_cnt", match_cnt, 1);

    start(16'hBBBB, 16, 15); wait_done("t8");
    check("t8_len", cap.size(), 256); check("t8_done_n", done_n, 1);
    check("t8_cnt_sat", match_cnt, 31);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
